// File: rtl/ym_bus_pkg.sv
// ============================================================================
// Module   : ym_bus_pkg
// Brief    : States, default timing and status bit position for ym_bus_master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ym_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_POLL_RD   = 4'd1,
    ST_POLL_GAP  = 4'd2,
    ST_AW_SETUP  = 4'd3,
    ST_AW_STROBE = 4'd4,
    ST_AW_HOLD   = 4'd5,
    ST_DW_SETUP  = 4'd6,
    ST_DW_STROBE = 4'd7,
    ST_DW_HOLD   = 4'd8
  } ym_state_e;

  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_STROBE_CYC   = 4;
  localparam int DEF_HOLD_CYC     = 2;
  localparam int DEF_POLL_GAP     = 8;
  localparam int DEF_BUSY_TIMEOUT = 4096;
  localparam int YM_BUSY_BIT      = 7;

  function automatic int ym_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ym_bus_master.sv
// ============================================================================
// Module   : ym_bus_master
// Brief    : YM2151-style bus initiator: busy poll, then address and data write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ym_bus_master
  import ym_bus_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int POLL_GAP     = DEF_POLL_GAP,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_done,
  output logic       o_timeout,
  output logic [7:0] o_status,
  output logic       o_cs_n,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic       o_a0,
  output logic [7:0] o_data_out,
  output logic       o_data_oe,
  input  logic [7:0] i_data_in
);

  localparam int PH_MAX = ym_max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, POLL_GAP);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int PC_W   = $clog2(BUSY_TIMEOUT + 1);

  // Phase counter holds remaining cycles minus one, so it is reloaded with len-1.
  localparam logic [PH_W-1:0] c_ld_setup  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] c_ld_strobe = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0] c_ld_hold   = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0] c_ld_gap    = PH_W'(POLL_GAP - 1);
  localparam logic [PC_W-1:0] c_timeout   = PC_W'(BUSY_TIMEOUT);

  ym_state_e       r_state;
  ym_state_e       w_state_nxt;
  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_load_val;
  logic [PC_W-1:0] r_poll;
  logic [PC_W-1:0] w_poll_inc;
  logic [7:0]      r_addr;
  logic [7:0]      r_data;
  logic [7:0]      r_status;
  logic            r_done;
  logic            r_timeout;
  logic            r_live;
  logic            w_load;
  logic            w_accept;
  logic            w_done_set;
  logic            w_to_set;
  logic            w_ready;
  logic            w_ph_last;
  logic            w_sample;
  logic            w_busy_in;

  assign w_ready    = r_live && (r_state == ST_IDLE);
  assign w_ph_last  = (r_phase == '0);
  assign w_busy_in  = i_data_in[YM_BUSY_BIT];
  assign w_poll_inc = r_poll + PC_W'(1);
  assign w_sample   = (r_state == ST_POLL_RD) && w_ph_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_poll    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_status  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_state   <= w_state_nxt;
      r_done    <= w_done_set;
      r_timeout <= w_to_set;
      if (w_load) begin
        r_phase <= w_load_val;
      end else if (!w_ph_last) begin
        r_phase <= r_phase - PH_W'(1);
      end
      if (w_accept) begin
        r_addr <= i_req_addr;
        r_data <= i_req_data;
        r_poll <= '0;
      end
      if (w_sample) begin
        r_status <= i_data_in;
        if (w_busy_in) r_poll <= w_poll_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_accept    = 1'b0;
    w_done_set  = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_req_valid && w_ready) begin
        w_accept = 1'b1; w_state_nxt = ST_POLL_RD; w_load = 1'b1; w_load_val = c_ld_strobe;
      end
      // Gap length is chosen from the live byte so the decision needs no extra cycle.
      ST_POLL_RD: if (w_ph_last) begin
        w_state_nxt = ST_POLL_GAP; w_load = 1'b1;
        w_load_val  = (w_busy_in && (w_poll_inc != c_timeout)) ? c_ld_gap : '0;
      end
      ST_POLL_GAP: if (w_ph_last) begin
        if (!r_status[YM_BUSY_BIT]) begin
          w_state_nxt = ST_AW_SETUP; w_load = 1'b1; w_load_val = c_ld_setup;
        end else if (r_poll == c_timeout) begin
          w_state_nxt = ST_IDLE; w_to_set = 1'b1;
        end else begin
          w_state_nxt = ST_POLL_RD; w_load = 1'b1; w_load_val = c_ld_strobe;
        end
      end
      ST_AW_SETUP:  if (w_ph_last) begin w_state_nxt = ST_AW_STROBE; w_load = 1'b1; w_load_val = c_ld_strobe; end
      ST_AW_STROBE: if (w_ph_last) begin w_state_nxt = ST_AW_HOLD;   w_load = 1'b1; w_load_val = c_ld_hold;   end
      ST_AW_HOLD:   if (w_ph_last) begin w_state_nxt = ST_DW_SETUP;  w_load = 1'b1; w_load_val = c_ld_setup;  end
      ST_DW_SETUP:  if (w_ph_last) begin w_state_nxt = ST_DW_STROBE; w_load = 1'b1; w_load_val = c_ld_strobe; end
      ST_DW_STROBE: if (w_ph_last) begin w_state_nxt = ST_DW_HOLD;   w_load = 1'b1; w_load_val = c_ld_hold;   end
      ST_DW_HOLD:   if (w_ph_last) begin w_state_nxt = ST_IDLE; w_done_set = 1'b1; end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cs_n     = 1'b1;
    o_wr_n     = 1'b1;
    o_rd_n     = 1'b1;
    o_a0       = 1'b0;
    o_data_out = '0;
    o_data_oe  = 1'b0;
    case (r_state)
      ST_POLL_RD:   begin o_cs_n = 1'b0; o_rd_n = 1'b0; end
      ST_AW_SETUP:  begin o_cs_n = 1'b0; o_data_oe = 1'b1; o_data_out = r_addr; end
      ST_AW_STROBE: begin o_cs_n = 1'b0; o_wr_n = 1'b0; o_data_oe = 1'b1; o_data_out = r_addr; end
      ST_AW_HOLD:   begin o_data_oe = 1'b1; o_data_out = r_addr; end
      ST_DW_SETUP:  begin o_cs_n = 1'b0; o_a0 = 1'b1; o_data_oe = 1'b1; o_data_out = r_data; end
      ST_DW_STROBE: begin o_cs_n = 1'b0; o_wr_n = 1'b0; o_a0 = 1'b1; o_data_oe = 1'b1; o_data_out = r_data; end
      ST_DW_HOLD:   begin o_a0 = 1'b1; o_data_oe = 1'b1; o_data_out = r_data; end
      default:      ;
    endcase
  end

  assign o_req_ready = w_ready;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_status    = r_status;

endmodule

`default_nettype wire
